// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register for the five-stage MIPS core.
// Owns the PC, applies decode-stage redirects with branch-delay-slot semantics.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          IM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [1:0]           pc_sel,
  input  logic [31:0]          jr_target,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic [31:0]          im_rdata,
  output logic [31:0]          pc_f,
  output logic [31:0]          instr1,
  output logic [31:0]          pc4_d,
  output logic [31:0]          pc8_d,
  output logic                 fetch_err
);

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BEQ = 2'b01,
    SEL_J   = 2'b10,
    SEL_JR  = 2'b11
  } pc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  // 33-bit so a full 2^30-word window does not overflow the bound.
  localparam logic [32:0] IM_BYTES = 33'd1 << (IM_ADDR_W + 2);
  localparam logic [31:0] NOP      = 32'h0000_0000;

  ifid_t       ifid_q;
  logic [31:0] pc_off;
  logic [31:0] pc_seq;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] pc_next;
  logic [31:0] fetch_word;
  logic        legal;

  assign pc_off  = pc_f - RESET_PC;
  assign im_addr = pc_off[IM_ADDR_W+1:2];

  // Once pc_f >= RESET_PC the offset cannot wrap, so the upper bound is a plain compare.
  assign legal = (pc_f[1:0] == 2'b00) && (pc_f >= RESET_PC) &&
                 ({1'b0, pc_off} < IM_BYTES);

  assign fetch_word = legal ? im_rdata : NOP;

  assign pc_seq = pc_f + 32'd4;
  assign br_tgt = ifid_q.pc4 + {{14{ifid_q.instr[15]}}, ifid_q.instr[15:0], 2'b00};
  assign j_tgt  = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};

  always_comb begin
    pc_next = pc_seq;
    case (pc_sel_e'(pc_sel))
      SEL_SEQ: pc_next = pc_seq;
      SEL_BEQ: pc_next = br_tgt;
      SEL_J:   pc_next = j_tgt;
      SEL_JR:  pc_next = jr_target;
      default: pc_next = pc_seq;
    endcase
  end

  // The delay slot is whatever sits in F during a redirect; it is always captured.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f      <= RESET_PC;
      ifid_q    <= '0;
      fetch_err <= 1'b0;
    end else if (!stall) begin
      pc_f         <= pc_next;
      ifid_q.instr <= fetch_word;
      ifid_q.pc4   <= pc_seq;
      fetch_err    <= fetch_err | ~legal;
    end
  end

  assign instr1 = ifid_q.instr;
  assign pc4_d  = ifid_q.pc4;
  assign pc8_d  = ifid_q.pc4 + 32'd4;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. It produces the instruction stream that the decode, execute, memory and write-back controllers consume. It owns the PC, drives the instruction-memory read address and captures each fetched word into the IF/ID register as `instr1`. It applies the decode-stage PC selection (sequential, beq, j/jal, jr/jalr) with MIPS branch-delay-slot semantics.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC value after reset; base address of instruction memory.
- `IM_ADDR_W`, 10: instruction-memory word-address width (2^IM_ADDR_W words).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of `clk`).
- `stall`  in  1  from the hazard unit; 1 freezes the PC and the IF/ID register.
- `pc_sel`  in  2  decode-stage next-PC select: 00 = PC+4, 01 = beq taken, 10 = j/jal, 11 = jr/jalr.
- `jr_target`  in  32  forwarded rs value; used when `pc_sel`=11.
- `im_addr`  out  IM_ADDR_W  word address to instruction memory (combinational).
- `im_rdata`  in  32  instruction word at `im_addr` (combinational read).
- `pc_f`  out  32  current fetch PC.
- `instr1`  out  32  IF/ID instruction, consumed by decode.
- `pc4_d`  out  32  IF/ID PC+4 of `instr1`.
- `pc8_d`  out  32  `pc4_d`+4; link value for jal/jalr.
- `fetch_err`  out  1  sticky: set when a fetch was attempted at an illegal PC.

## Operation
- `im_addr` = (`pc_f` − `RESET_PC`)[IM_ADDR_W+1:2].
- A PC is legal when `pc_f[1:0]`=00 and `RESET_PC` ≤ `pc_f` < `RESET_PC` + 4·2^IM_ADDR_W. Comparisons are unsigned 32-bit.
- The fetched word is `im_rdata` if the PC is legal. Otherwise it is 32'h0000_0000 (nop), and `fetch_err` sets on that edge, provided `stall`=0.
- Next-PC candidates, all 32-bit with wrap-around and no carry-out:
  - 00: `pc_f`+4.
  - 01: `pc4_d` + (sign_extend(`instr1[15:0]`) << 2).
  - 10: {`pc4_d[31:28]`, `instr1[25:0]`, 2'b00}.
  - 11: `jr_target`, used unmodified (an illegal target is caught by the legality check).
- Delay slot: the instruction in F when `pc_sel`≠00 is the delay slot. It is always captured into IF/ID and is never squashed.
- Update priority on each rising edge:
  - `reset`=0: `pc_f`←`RESET_PC`, `instr1`←0, `pc4_d`←0, `fetch_err`←0.
  - Else if `stall`=1: all registers hold. `pc_sel` is ignored; because decode is frozen it is re-presented on the next cycle.
  - Else: `pc_f`←selected next PC, `instr1`←fetched word, `pc4_d`←`pc_f`+4, and `fetch_err`←`fetch_err` | illegal.
- `pc8_d` = `pc4_d`+4 (combinational).
- `fetch_err` clears only on reset. Fetch continues after an error, issuing nops until a redirect reaches a legal PC.

## Timing
- Reset values: `pc_f`=`RESET_PC`, `instr1`=0, `pc4_d`=0, `pc8_d`=4, `fetch_err`=0, and `im_addr`=0.
- Latency: a word addressed in cycle n appears on `instr1` in cycle n+1.
- A redirect asserted in cycle n, while its branch is in D, takes effect on `pc_f` at cycle n+1. The delay slot enters D at n+1 and the target instruction enters D at n+2.
- When stall and redirect are asserted together, stall wins. The redirect is applied on the first unstalled edge.
- Reset mid-stall or mid-redirect: reset wins and no partial update is permitted.

## Test plan
- Reset then sequential run, IM holding words W0..W3: `pc_f` = 0x3000, 0x3004, 0x3008, … and `instr1` = 0, W0, W1, … with `pc4_d` = 0x3004 alongside W0.
- beq at 0x3008 with imm = 0xFFFE and `pc_sel`=01 while it is in D: the delay slot at 0x300C is captured. The next `pc_f` is 0x300C + (−8) = 0x3004.
- j with instr_index 0x0000C10 in D (pc4_d = 0x3010) and `pc_sel`=10: the next `pc_f` is 0x0000_3040.
- jr with `jr_target` = 0x3020 and `stall` held for 2 cycles together with `pc_sel`=11: `pc_f` and `instr1` are frozen for 2 cycles, then `pc_f` = 0x3020.
- jr to 0x3002 (misaligned) and a jump to 0x4000 (beyond 1 KiW): `instr1` = 0 for each and `fetch_err` = 1 and stays 1. A later jr to 0x3000 resumes valid fetch.
- Drive `reset`=0 in the cycle a redirect is asserted: next state is `pc_f` = 0x3000, `instr1` = 0 and `fetch_err` = 0.
